// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: tracks EX/MEM destinations, registers EX forward selects,
// raises load-use stalls and branch flushes, and freezes the pipe while the accelerator is busy.
module hazard_fwd_ctrl #(
    parameter int ACC_TIMEOUT = 256,
    parameter int CNT_W       = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       use_rs1_id,
    input  logic       use_rs2_id,
    input  logic [4:0] rd_id,
    input  logic       reg_write_id,
    input  logic       mem_read_id,
    input  logic       pc_src_ex,
    input  logic       acc_start_ex,
    input  logic       acc_done,
    output logic [1:0] rs1_fwd_ex,
    output logic [1:0] rs2_fwd_ex,
    output logic       stall_if,
    output logic       stall_id,
    output logic       flush_id,
    output logic       bubble_ex,
    output logic       stall_pipe,
    output logic       acc_busy,
    output logic       acc_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } acc_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_TIMEOUT - 1);

    // Destination tracking for the instructions currently in EX and MEM
    logic [4:0] ex_rd_reg, ex_rd_next;
    logic       ex_wr_reg, ex_wr_next;
    logic       ex_ld_reg, ex_ld_next;
    logic [4:0] mem_rd_reg;
    logic       mem_wr_reg;

    // Packed {rs1, rs2} forward selects, rs1 in the upper slice
    logic [3:0] fwd_reg, fwd_next;
    logic [3:0] fwd_calc;
    logic [1:0] load_use_src;

    logic [4:0] src_rs  [2];
    logic       src_use [2];

    acc_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout;

    logic busy;
    logic load_use;
    logic bubble_int;

    assign src_rs[0]  = rs2_id;
    assign src_rs[1]  = rs1_id;
    assign src_use[0] = use_rs2_id;
    assign src_use[1] = use_rs1_id;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic src_live;
            logic ex_hit;
            logic mem_hit;

            assign src_live = src_use[gi] && (src_rs[gi] != 5'd0);
            assign ex_hit   = src_live && ex_wr_reg && (ex_rd_reg == src_rs[gi]);
            assign mem_hit  = src_live && mem_wr_reg && (mem_rd_reg == src_rs[gi]);

            // The younger producer in EX wins over the one in MEM
            assign fwd_calc[2*gi +: 2] = ex_hit  ? 2'b01 :
                                         mem_hit ? 2'b10 : 2'b00;

            assign load_use_src[gi] = src_live && ex_ld_reg && (ex_rd_reg == src_rs[gi]);
        end
    endgenerate

    assign busy       = (state_reg == ST_BUSY);
    assign load_use   = |load_use_src;
    // A taken branch already bubbles EX, so a pending load-use stall is pointless that cycle
    assign bubble_int = !busy && (pc_src_ex || load_use);

    always_comb begin
        ex_rd_next = rd_id;
        ex_wr_next = reg_write_id;
        ex_ld_next = mem_read_id;
        fwd_next   = fwd_calc;
        if (bubble_int) begin
            ex_rd_next = 5'd0;
            ex_wr_next = 1'b0;
            ex_ld_next = 1'b0;
            fwd_next   = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rd_reg  <= 5'd0;
            ex_wr_reg  <= 1'b0;
            ex_ld_reg  <= 1'b0;
            mem_rd_reg <= 5'd0;
            mem_wr_reg <= 1'b0;
            fwd_reg    <= 4'b0000;
        end else if (!busy) begin
            ex_rd_reg  <= ex_rd_next;
            ex_wr_reg  <= ex_wr_next;
            ex_ld_reg  <= ex_ld_next;
            mem_rd_reg <= ex_rd_reg;
            mem_wr_reg <= ex_wr_reg;
            fwd_reg    <= fwd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Completion takes precedence over a timeout landing on the same cycle
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        timeout    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (acc_start_ex) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_next = cnt_reg + 1'b1;
                if (acc_done) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    timeout    = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign rs1_fwd_ex = fwd_reg[3:2];
    assign rs2_fwd_ex = fwd_reg[1:0];

    assign stall_if   = !rst && (busy || (load_use && !pc_src_ex));
    assign stall_id   = !rst && (busy || (load_use && !pc_src_ex));
    assign flush_id   = !rst && !busy && pc_src_ex;
    assign bubble_ex  = !rst && bubble_int;
    assign stall_pipe = !rst && busy;
    assign acc_busy   = !rst && busy;
    assign acc_err    = !rst && timeout;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed vector table, accelerator corner sequences,
// and randomized traffic checked against a stage-list reference model.
module tb_hazard_fwd_ctrl;

    localparam int ACC_TIMEOUT = 256;
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1101000;
    localparam logic [6:0] O_BR   = 7'b0011000;
    localparam logic [6:0] O_BUSY = 7'b1100110;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rd_id;
    logic       use_rs1_id, use_rs2_id, reg_write_id, mem_read_id;
    logic       pc_src_ex, acc_start_ex, acc_done;
    logic [1:0] rs1_fwd_ex, rs2_fwd_ex;
    logic       stall_if, stall_id, flush_id, bubble_ex, stall_pipe, acc_busy, acc_err;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_fwd_ctrl #(.ACC_TIMEOUT(ACC_TIMEOUT), .CNT_W(9)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .rd_id(rd_id), .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
        .pc_src_ex(pc_src_ex), .acc_start_ex(acc_start_ex), .acc_done(acc_done),
        .rs1_fwd_ex(rs1_fwd_ex), .rs2_fwd_ex(rs2_fwd_ex),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .bubble_ex(bubble_ex), .stall_pipe(stall_pipe),
        .acc_busy(acc_busy), .acc_err(acc_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       wr, ld, br;
        logic [6:0] exp_outs;
        logic [1:0] exp_f1, exp_f2;
    } vec_t;

    typedef struct {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } slot_t;

    vec_t  vecs[20];
    slot_t pipe[2];   // index 0 = EX, 1 = MEM
    logic [1:0] m_f1, m_f2;
    logic  m_busy;
    int    m_busy_cycles;

    function automatic logic [6:0] outs();
        return {stall_if, stall_id, flush_id, bubble_ex, stall_pipe, acc_busy, acc_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        rs1_id = 5'd0; rs2_id = 5'd0; use_rs1_id = 1'b0; use_rs2_id = 1'b0;
        rd_id = 5'd0; reg_write_id = 1'b0; mem_read_id = 1'b0; pc_src_ex = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        acc_start_ex = 1'b0;
        acc_done     = 1'b0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Forward code from the model: nearest stage holding a writer of rs (EX=01, MEM=10)
    function automatic logic [1:0] ref_code(input logic [4:0] rs, input logic used);
        if (!used || rs == 5'd0) return 2'b00;
        for (int s = 0; s < 2; s++)
            if (pipe[s].wr && pipe[s].rd == rs) return 2'(s + 1);
        return 2'b00;
    endfunction

    function automatic logic ref_load_use(input logic [4:0] rs, input logic used);
        return used && rs != 5'd0 && pipe[0].ld && pipe[0].rd == rs;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_cnt, err_cnt, err_at;

        vecs[0]  = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd1,  1'b1, 1'b0, 1'b0, O_NONE, 2'b00, 2'b00};
        vecs[1]  = '{5'd1,  5'd2, 1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, O_NONE, 2'b01, 2'b00};
        vecs[2]  = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, O_NONE, 2'b00, 2'b00};
        vecs[3]  = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd6,  1'b1, 1'b0, 1'b0, O_NONE, 2'b00, 2'b00};
        vecs[4]  = '{5'd5,  5'd6, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, O_NONE, 2'b10, 2'b01};
        vecs[5]  = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, O_NONE, 2'b00, 2'b00};
        vecs[6]  = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, O_NONE, 2'b00, 2'b00};
        vecs[7]  = '{5'd5,  5'd5, 1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, O_NONE, 2'b01, 2'b01};
        vecs[8]  = '{5'd0,  5'd0, 1'b1, 1'b1, 5'd2,  1'b0, 1'b0, 1'b0, O_NONE, 2'b00, 2'b00};
        vecs[9]  = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0, O_NONE, 2'b00, 2'b00};
        vecs[10] = '{5'd7,  5'd3, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, O_LU,   2'b00, 2'b00};
        vecs[11] = '{5'd7,  5'd3, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, O_NONE, 2'b10, 2'b00};
        vecs[12] = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b1, 1'b0, O_NONE, 2'b00, 2'b00};
        vecs[13] = '{5'd9,  5'd8, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, O_BR,   2'b00, 2'b00};
        vecs[14] = '{5'd9,  5'd9, 1'b1, 1'b0, 5'd4,  1'b1, 1'b0, 1'b0, O_NONE, 2'b10, 2'b00};
        vecs[15] = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, O_NONE, 2'b00, 2'b00};
        vecs[16] = '{5'd10, 5'd4, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, O_NONE, 2'b00, 2'b10};
        vecs[17] = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, O_NONE, 2'b00, 2'b00};
        vecs[18] = '{5'd0,  5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_NONE, 2'b00, 2'b00};
        vecs[19] = '{5'd3,  5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, O_BR,   2'b00, 2'b00};

        // Reset state
        do_reset();
        @(negedge clk);
        check("reset_outs", outs(), O_NONE);
        check("reset_fwd", {rs1_fwd_ex, rs2_fwd_ex}, 4'b0000);
        step();

        // Directed vector table, one ID instruction per cycle
        for (int i = 0; i < 20; i++) begin
            rs1_id = vecs[i].rs1; rs2_id = vecs[i].rs2;
            use_rs1_id = vecs[i].u1; use_rs2_id = vecs[i].u2;
            rd_id = vecs[i].rd; reg_write_id = vecs[i].wr;
            mem_read_id = vecs[i].ld; pc_src_ex = vecs[i].br;
            @(negedge clk);
            check($sformatf("vec%0d_outs", i), outs(), vecs[i].exp_outs);
            step();
            check($sformatf("vec%0d_fwd", i), {rs1_fwd_ex, rs2_fwd_ex},
                  {vecs[i].exp_f1, vecs[i].exp_f2});
            $display("vec %0d: rs1=%0d rs2=%0d rd=%0d outs=%b fwd=%b/%b",
                     i, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, outs(), rs1_fwd_ex, rs2_fwd_ex);
        end

        // Accelerator busy for 5 cycles: pipe frozen, branch masked, tracking held
        do_reset();
        rd_id = 5'd1; reg_write_id = 1'b1;
        step();
        idle_inputs();
        rs1_id = 5'd1; use_rs1_id = 1'b1; rd_id = 5'd4; reg_write_id = 1'b1; acc_start_ex = 1'b1;
        step();
        acc_start_ex = 1'b0;
        check("acc_pre_fwd", {rs1_fwd_ex, rs2_fwd_ex}, 4'b0100);
        rs1_id = 5'd2; rd_id = 5'd9; pc_src_ex = 1'b1;
        busy_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) acc_done = 1'b1;
            @(negedge clk);
            check($sformatf("acc_busy_outs_c%0d", k), outs(), O_BUSY);
            check($sformatf("acc_hold_fwd_c%0d", k), {rs1_fwd_ex, rs2_fwd_ex}, 4'b0100);
            step();
            acc_done = 1'b0;
        end
        idle_inputs();
        rs1_id = 5'd4; use_rs1_id = 1'b1; rs2_id = 5'd1; use_rs2_id = 1'b1;
        @(negedge clk);
        check("acc_release_outs", outs(), O_NONE);
        step();
        check("acc_held_tracking_fwd", {rs1_fwd_ex, rs2_fwd_ex}, 4'b0110);
        $display("acc 5-cycle sequence: fwd=%b/%b", rs1_fwd_ex, rs2_fwd_ex);

        // Timeout: no acc_done, err pulse on the 256th busy cycle
        do_reset();
        acc_start_ex = 1'b1;
        step();
        acc_start_ex = 1'b0;
        busy_cnt = 0; err_cnt = 0; err_at = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (acc_busy) busy_cnt++;
            if (acc_err) begin
                err_cnt++;
                err_at = busy_cnt;
            end
            step();
        end
        check("timeout_busy_cycles", busy_cnt, 256);
        check("timeout_err_at", err_at, 256);
        check("timeout_err_pulses", err_cnt, 1);
        check("timeout_then_idle", acc_busy, 1'b0);
        $display("timeout sequence: busy=%0d err_at=%0d pulses=%0d", busy_cnt, err_at, err_cnt);

        // Reset while busy on the would-be timeout cycle
        do_reset();
        acc_start_ex = 1'b1;
        step();
        acc_start_ex = 1'b0;
        repeat (254) step();
        @(negedge clk);
        check("rst_busy_before", acc_busy, 1'b1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy_no_err", acc_err, 1'b0);
        step();
        rst = 1'b0;
        err_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (acc_err || acc_busy) err_cnt++;
            step();
        end
        check("rst_busy_idle_after", err_cnt, 0);
        $display("reset-in-busy sequence done");

        // acc_done alone in IDLE is ignored; start+done together enters BUSY
        do_reset();
        acc_done = 1'b1;
        step();
        check("done_in_idle_ignored", acc_busy, 1'b0);
        acc_start_ex = 1'b1;
        step();
        acc_start_ex = 1'b0; acc_done = 1'b0;
        check("start_with_done_busy", acc_busy, 1'b1);
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        check("done_ends_busy", acc_busy, 1'b0);
        $display("start/done overlap sequence done");

        // Randomized traffic against the stage-list model
        do_reset();
        pipe[0] = '{5'd0, 1'b0, 1'b0};
        pipe[1] = '{5'd0, 1'b0, 1'b0};
        m_f1 = 2'b00; m_f2 = 2'b00; m_busy = 1'b0; m_busy_cycles = 0;
        for (int c = 0; c < 1500; c++) begin
            logic hz, bub;
            logic [6:0] exp_o;
            logic [1:0] c1, c2;
            rs1_id = 5'($urandom_range(0, 7));
            rs2_id = 5'($urandom_range(0, 7));
            rd_id  = 5'($urandom_range(0, 7));
            use_rs1_id   = 1'($urandom_range(0, 1));
            use_rs2_id   = 1'($urandom_range(0, 1));
            reg_write_id = ($urandom_range(0, 3) != 0);
            mem_read_id  = ($urandom_range(0, 2) == 0);
            pc_src_ex    = ($urandom_range(0, 7) == 0);
            acc_start_ex = ($urandom_range(0, 15) == 0);
            acc_done     = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            hz = ref_load_use(rs1_id, use_rs1_id) || ref_load_use(rs2_id, use_rs2_id);
            if (m_busy)
                exp_o = {O_BUSY[6:1], (m_busy_cycles == ACC_TIMEOUT - 1) && !acc_done};
            else
                exp_o = {hz && !pc_src_ex, hz && !pc_src_ex, pc_src_ex, pc_src_ex || hz, 3'b000};
            check($sformatf("rand%0d_outs", c), outs(), exp_o);
            if (!m_busy) begin
                bub = pc_src_ex || hz;
                c1 = bub ? 2'b00 : ref_code(rs1_id, use_rs1_id);
                c2 = bub ? 2'b00 : ref_code(rs2_id, use_rs2_id);
                pipe[1] = pipe[0];
                pipe[0] = bub ? '{5'd0, 1'b0, 1'b0} : '{rd_id, reg_write_id, mem_read_id};
                m_f1 = c1; m_f2 = c2;
            end
            if (m_busy) begin
                m_busy_cycles++;
                if (acc_done || m_busy_cycles == ACC_TIMEOUT) begin
                    m_busy = 1'b0;
                    m_busy_cycles = 0;
                end
            end else if (acc_start_ex) begin
                m_busy = 1'b1;
                m_busy_cycles = 0;
            end
            step();
            check($sformatf("rand%0d_fwd", c), {rs1_fwd_ex, rs2_fwd_ex}, {m_f1, m_f2});
            if (c % 250 == 249)
                $display("random cycles up to %0d applied", c + 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
